// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - N-channel memory request arbiter with in-order response routing
// Optional: define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mem_req_arbiter #(
    parameter int NCH     = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NCH-1:0]           ch_req,
    input  logic [NCH-1:0]           ch_wr,
    input  logic [2*NCH-1:0]         ch_size,
    input  logic [NCH*DATA_W/8-1:0]  ch_wstrb,
    input  logic [NCH*ADDR_W-1:0]    ch_addr,
    input  logic [NCH*DATA_W-1:0]    ch_wdata,
    output logic [NCH-1:0]           ch_addr_ok,
    output logic [NCH-1:0]           ch_data_ok,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic                     mem_req,
    output logic                     mem_wr,
    output logic [1:0]               mem_size,
    output logic [DATA_W/8-1:0]      mem_wstrb,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_addr_ok,
    input  logic                     mem_data_ok,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int SW = DATA_W / 8;
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state, state_nx;
    logic [GW-1:0]   grant, grant_nx, pick;
    logic [CW-1:0]   count;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [GW-1:0]   id_fifo [MAX_OUT];
    logic            push, pop;
    logic [NCH-1:0]  req_shift;

`ifdef MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        pick      = '0;
        req_shift = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            req_shift = ch_req >> i;
            if (req_shift[0]) pick = GW'(i);
        end
    end
`else
    logic [GW-1:0]   rr_last;
    logic            rr_found;
    int              rr_idx;

    // Search starts just past the last accepted channel so every requester is served in turn.
    always_comb begin
        pick      = '0;
        rr_found  = 1'b0;
        rr_idx    = 0;
        req_shift = '0;
        for (int i = 1; i <= NCH; i++) begin
            rr_idx    = (int'(rr_last) + i) % NCH;
            req_shift = ch_req >> rr_idx;
            if (!rr_found && req_shift[0]) begin
                pick     = GW'(rr_idx);
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)   rr_last <= GW'(NCH - 1);
        else if (push) rr_last <= grant;
    end
`endif

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        mem_req  = 1'b0;
        push     = 1'b0;
        case (state)
            IDLE: begin
                // Judged on the registered count: a pop this cycle does not open a slot yet.
                if ((|ch_req) && (count < CW'(MAX_OUT))) begin
                    state_nx = HOLD;
                    grant_nx = pick;
                end
            end
            HOLD: begin
                mem_req = 1'b1;
                if (mem_addr_ok) begin
                    push     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign pop        = mem_data_ok && (count != '0);
    assign ch_addr_ok = push ? (NCH'(1) << grant) : '0;
    assign ch_data_ok = pop ? (NCH'(1) << id_fifo[rd_ptr]) : '0;
    assign ch_rdata   = mem_rdata;

    assign mem_wr     = ch_wr[grant];
    assign mem_size   = ch_size[int'(grant) * 2 +: 2];
    assign mem_wstrb  = ch_wstrb[int'(grant) * SW +: SW];
    assign mem_addr   = ch_addr[int'(grant) * ADDR_W +: ADDR_W];
    assign mem_wdata  = ch_wdata[int'(grant) * DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            grant  <= '0;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_nx;
            grant <= grant_nx;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MAX_OUT; i++) id_fifo[i] <= '0;
        end else if (push) begin
            id_fifo[wr_ptr] <= grant;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - scoreboard bench for mem_req_arbiter with a behavioural arbitration model
`timescale 1ns/1ps
module tb_mem_req_arbiter;

    localparam int NCH     = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int SW      = DW / 8;
    localparam int MAX_OUT = 4;

    logic                clk = 1'b0;
    logic                resetn;
    logic [NCH-1:0]      ch_req, ch_wr, ch_addr_ok, ch_data_ok;
    logic [2*NCH-1:0]    ch_size;
    logic [NCH*SW-1:0]   ch_wstrb;
    logic [NCH*AW-1:0]   ch_addr;
    logic [NCH*DW-1:0]   ch_wdata;
    logic [DW-1:0]       ch_rdata;
    logic                mem_req, mem_wr;
    logic [1:0]          mem_size;
    logic [SW-1:0]       mem_wstrb;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic                mem_addr_ok, mem_data_ok;
    logic [DW-1:0]       mem_rdata;

    always #5 clk = ~clk;

    mem_req_arbiter #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .resetn(resetn),
        .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size), .ch_wstrb(ch_wstrb),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Stimulus side: per-channel request queues, directed response data, issued response log.
    req_t         cq [NCH][$];
    int           pop_cnt [NCH];
    logic [DW-1:0] dq[$];
    logic [DW-1:0] rsp_q[$];
    int           aok_prob, dok_prob, seq;
    bit           final_chk;

    // Monitor side: reference model state and counters.
    int           ok_cnt [NCH];
    int           acc_q[$];
    int           acc_rd, rsp_rd, model_cnt, last, win, prev_cnt, n_acc;
    bit           idle_ok, prev_mreq, prev_acc, final_done;
    logic [NCH-1:0] prev_req;
    int           n_chk, n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NCH-1:0] onehot(input int c);
        logic [NCH-1:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    // Winner according to the arbitration rule, given the requesters seen in the deciding cycle.
    function automatic int model_pick(input logic [NCH-1:0] req, input int last_g);
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int c = 0; c < NCH; c++) if (req[c]) return c;
`else
        for (int k = 1; k <= NCH; k++) if (req[(last_g + k) % NCH]) return (last_g + k) % NCH;
`endif
        return 0;
    endfunction

    always @(negedge clk) begin : monitor
        int  cnt0;
        bit  acc, pop, exp_hold;
        if (!resetn) begin
            chk("rst_mem_req", 64'(mem_req), 64'd0);
            chk("rst_addr_ok", 64'(ch_addr_ok), 64'd0);
            chk("rst_data_ok", 64'(ch_data_ok), 64'd0);
            acc_q.delete();
            acc_rd    = 0;
            model_cnt = 0;
            last      = NCH - 1;
            idle_ok   = 1'b0;
            prev_mreq = 1'b0;
            prev_acc  = 1'b0;
            rsp_rd    = rsp_q.size();
        end else begin
            cnt0 = model_cnt;
            if (idle_ok) begin
                exp_hold = (prev_req != '0) && (prev_cnt < MAX_OUT);
                chk("hold_entry", 64'(mem_req), 64'(exp_hold));
                if (exp_hold) win = model_pick(prev_req, last);
            end
            if (prev_mreq && !prev_acc) chk("hold_stay", 64'(mem_req), 64'd1);
            acc = mem_req && mem_addr_ok;
            if (acc) begin
                chk("addr_ok", 64'(ch_addr_ok), 64'(onehot(win)));
                chk("mem_addr", 64'(mem_addr), 64'(ch_addr[win*AW +: AW]));
                chk("mem_fields", 64'({mem_wr, mem_size, mem_wstrb, mem_wdata}),
                    64'({ch_wr[win], ch_size[2*win +: 2], ch_wstrb[SW*win +: SW], ch_wdata[DW*win +: DW]}));
                acc_q.push_back(win);
                last = win;
                ok_cnt[win]++;
                n_acc++;
            end else begin
                chk("addr_ok_idle", 64'(ch_addr_ok), 64'd0);
            end
            pop = mem_data_ok && (cnt0 > 0);
            if (pop) begin
                chk("data_ok", 64'(ch_data_ok), 64'(onehot(acc_q[acc_rd])));
                chk("rdata", 64'(ch_rdata), 64'(rsp_q[rsp_rd]));
                acc_rd++;
            end else begin
                chk("data_ok_idle", 64'(ch_data_ok), 64'd0);
            end
            if (mem_data_ok) rsp_rd++;
            model_cnt = cnt0 + int'(acc) - int'(pop);
            idle_ok   = !mem_req;
            prev_req  = ch_req;
            prev_cnt  = cnt0;
            prev_mreq = mem_req;
            prev_acc  = acc;
            if (final_chk && !final_done) begin
                chk("drained", 64'(acc_rd), 64'(acc_q.size()));
                chk("enough_traffic", 64'(n_acc >= 30), 64'd1);
                final_done = 1'b1;
            end
        end
    end

    function automatic req_t mkreq(input int c, input logic wr, input logic [31:0] addr);
        req_t r;
        r.wr    = wr;
        r.size  = 2'd2;
        r.wstrb = 4'hf;
        r.addr  = addr;
        r.wdata = $urandom;
        return r;
    endfunction

    function automatic req_t rndreq(input int c, input int s);
        req_t r;
        r.wr    = 1'($urandom_range(1));
        r.size  = 2'($urandom_range(2));
        r.wstrb = 4'($urandom_range(15));
        r.addr  = (32'(c) << 28) | (32'(s) << 2);
        r.wdata = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) begin
            while (pop_cnt[c] < ok_cnt[c]) begin
                if (cq[c].size() > 0) cq[c].delete(0);
                pop_cnt[c]++;
            end
            if (cq[c].size() > 0) begin
                ch_req[c]             = 1'b1;
                ch_wr[c]              = cq[c][0].wr;
                ch_size[2*c +: 2]     = cq[c][0].size;
                ch_wstrb[SW*c +: SW]  = cq[c][0].wstrb;
                ch_addr[AW*c +: AW]   = cq[c][0].addr;
                ch_wdata[DW*c +: DW]  = cq[c][0].wdata;
            end else begin
                ch_req[c] = 1'b0;
            end
        end
        mem_addr_ok = (int'($urandom_range(99)) < aok_prob);
        if (dq.size() > 0) begin
            mem_data_ok = 1'b1;
            mem_rdata   = dq.pop_front();
            rsp_q.push_back(mem_rdata);
        end else if (int'($urandom_range(99)) < dok_prob) begin
            mem_data_ok = 1'b1;
            mem_rdata   = $urandom;
            rsp_q.push_back(mem_rdata);
        end else begin
            mem_data_ok = 1'b0;
            mem_rdata   = $urandom;
        end
    endtask

    initial begin
        resetn = 1'b0;
        ch_req = '0; ch_wr = '0; ch_size = '0; ch_wstrb = '0; ch_addr = '0; ch_wdata = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        aok_prob = 0; dok_prob = 0; seq = 0; final_chk = 1'b0;
        n_chk = 0; n_fail = 0; n_acc = 0; final_done = 1'b0; win = 0;
        for (int c = 0; c < NCH; c++) begin pop_cnt[c] = 0; ok_cnt[c] = 0; end
        repeat (3) tick();
        resetn = 1'b1;

        // Single channel read, acceptance held off for two HOLD cycles, late response.
        cq[1].push_back(mkreq(1, 1'b0, 32'h0001_000c));
        repeat (3) tick();
        aok_prob = 100;
        tick();
        aok_prob = 0;
        repeat (2) tick();
        dq.push_back(32'hdeadbeef);
        repeat (4) tick();

        // Both channels requesting continuously, bus always accepting.
        for (int i = 0; i < 6; i++) begin
            cq[0].push_back(mkreq(0, 1'b0, 32'h0000_0100 + 32'(i * 4)));
            cq[1].push_back(mkreq(1, 1'b1, 32'h1000_0100 + 32'(i * 4)));
        end
        aok_prob = 100; dok_prob = 100;
        repeat (36) tick();
        aok_prob = 0;
        repeat (6) tick();
        dok_prob = 0;

        // Fill all outstanding slots, then free one.
        aok_prob = 100;
        for (int i = 0; i < 5; i++) cq[0].push_back(mkreq(0, 1'b0, 32'h0000_2000 + 32'(i * 4)));
        repeat (14) tick();
        dq.push_back(32'h0000_00a1);
        repeat (6) tick();
        for (int i = 0; i < 4; i++) dq.push_back(32'h0000_00b0 + 32'(i));
        repeat (8) tick();

        // Interleaved ch0, ch1, ch0 with in-order responses.
        cq[0].push_back(mkreq(0, 1'b0, 32'h0000_3000));
        tick();
        cq[1].push_back(mkreq(1, 1'b0, 32'h1000_3000));
        cq[0].push_back(mkreq(0, 1'b1, 32'h0000_3004));
        repeat (10) tick();
        dq.push_back(32'h11); dq.push_back(32'h22); dq.push_back(32'h33);
        repeat (6) tick();

        // Stray response with nothing outstanding.
        dq.push_back(32'h5555_aaaa);
        repeat (3) tick();

        // Reset while in HOLD with two outstanding.
        cq[0].push_back(mkreq(0, 1'b0, 32'h0000_4000));
        cq[1].push_back(mkreq(1, 1'b0, 32'h1000_4000));
        repeat (5) tick();
        aok_prob = 0;
        cq[0].push_back(mkreq(0, 1'b0, 32'h0000_4004));
        repeat (3) tick();
        resetn = 1'b0;
        for (int c = 0; c < NCH; c++) begin cq[c].delete(); pop_cnt[c] = ok_cnt[c]; end
        tick();
        resetn = 1'b1;
        dq.push_back(32'h0bad_0001); dq.push_back(32'h0bad_0002);
        repeat (4) tick();

        // Randomised traffic.
        aok_prob = 60; dok_prob = 35;
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if (cq[c].size() < 3 && $urandom_range(99) < 30) begin
                    seq++;
                    cq[c].push_back(rndreq(c, seq));
                end
            end
            tick();
        end
        aok_prob = 100; dok_prob = 50;
        repeat (100) tick();
        aok_prob = 0; dok_prob = 100;
        repeat (20) tick();
        final_chk = 1'b1;
        repeat (2) tick();
        if (!final_done) begin
            n_fail++;
            $display("FAIL final_check: got not_run expected run");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Parametrised N-channel arbiter joining CPU memory request channels (e.g. inst fetch and data access) onto one shared SRAM-like bus with split address/data handshakes.
- Replaces the tied-off ready/valid of the single-cycle SRAM attach.
- Allows multiple outstanding requests and returns responses in order to the originating channel.
- Sits between the pipeline stages and the memory bridge inside the CPU top.

Parameters:
NCH, 2, number of requesting channels (>=2)
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width DATA_W/8
MAX_OUT, 4, maximum outstanding accepted-but-unanswered requests (power of 2, >=2)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
ch_req  in  NCH  per-channel request valid
ch_wr  in  NCH  per-channel write (1) / read (0)
ch_size  in  2*NCH  per-channel size: 0=byte, 1=half, 2=word
ch_wstrb  in  NCH*DATA_W/8  per-channel byte strobes
ch_addr  in  NCH*ADDR_W  per-channel address
ch_wdata  in  NCH*DATA_W  per-channel write data
ch_addr_ok  out  NCH  request accepted this cycle
ch_data_ok  out  NCH  response for that channel this cycle
ch_rdata  out  DATA_W  response data, broadcast to all channels
mem_req  out  1  downstream request valid
mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/2/DATA_W/8/ADDR_W/DATA_W  fields of the granted channel
mem_addr_ok  in  1  downstream accepted request
mem_data_ok  in  1  downstream response valid (in order)
mem_rdata  in  DATA_W  downstream response data

Behaviour:
- Reset: all internal state cleared immediately on resetn low. ch_addr_ok=0, ch_data_ok=0, mem_req=0. FIFO count=0, state IDLE, rr_last=NCH-1.
- FSM IDLE:
  - If any ch_req and count<MAX_OUT: pick grant by round-robin, searching from rr_last+1 modulo NCH.
  - Register the grant index, go to HOLD.
  - mem_req is 0 in IDLE, giving one cycle of grant latency.
- FSM HOLD:
  - mem_req=1; mem_* fields are driven combinationally from the granted channel.
  - The granted channel must hold its fields until accepted; this is the channel's contract, not checked here.
  - On mem_addr_ok: ch_addr_ok[grant]=1 that cycle; push grant index into the ID FIFO; rr_last<=grant; return to IDLE.
  - Back-to-back requests therefore take 2 cycles each.
- mem_req never drops in HOLD before acceptance, even if ch_req[grant] falls.
- Entering HOLD is blocked when count==MAX_OUT, judged on the registered count; a pop in the same cycle does not unblock it.
- ID FIFO:
  - Depth MAX_OUT, log2(MAX_OUT)-bit pointers that wrap; count width log2(MAX_OUT)+1.
  - Push and pop in the same cycle leave count unchanged.
  - mem_addr_ok while full cannot occur, because HOLD is never entered when full.
- Response path:
  - On mem_data_ok with count>0: ch_data_ok[fifo_head]=1 and ch_rdata=mem_rdata, both combinational, same cycle; pop.
  - mem_data_ok with count==0 is ignored: no ch_data_ok and no pop.
- Writes also occupy an outstanding slot and receive a data_ok.
- At most one ch_addr_ok and at most one ch_data_ok bit is set per cycle.
- Reset mid-transaction drops all outstanding IDs. Responses arriving after reset are discarded by the count==0 rule.

Optional Feature:
- Macro MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest channel index wins; rr_last unused.
- Undefined: round-robin as above.

Test Plan:
- Single channel: ch_req[1]=1 read 0x1000c, mem_addr_ok after 2 cycles, mem_data_ok with 0xdeadbeef 3 cycles later -> mem_req high from cycle 1 until acceptance; ch_addr_ok[1] pulses once; ch_data_ok[1]=1 with ch_rdata=0xdeadbeef; ch_data_ok[0] never set.
- Both channels request continuously, mem_addr_ok always 1 -> grants alternate 0,1,0,1; with MEM_ARB_FIXED_PRIO_EN, grants are always 0.
- MAX_OUT=4, 4 reads accepted with no mem_data_ok -> count=4 and mem_req stays 0. One mem_data_ok -> the next HOLD starts one cycle later, not in the pop cycle.
- Interleaved accepts from ch0, ch1, ch0, then 3 responses 0x11, 0x22, 0x33 -> data_ok routed to ch0, ch1, ch0 with the matching data.
- Stray mem_data_ok with count==0 -> no ch_data_ok, count stays 0.
- resetn low for 1 cycle while in HOLD with 2 outstanding -> mem_req drops immediately; the following 2 responses produce no ch_data_ok.
